// File: rtl/rd_lane_monitor.sv
// Multi-lane 8b/10b running-disparity monitor: per-lane RD tracking, disparity/code
// violation pulses, saturating error counters and an acquire/check/locked state machine.
module rd_lane_monitor #(
   parameter int NUM_LANES     = 4,
   parameter int SYM_W         = 10,
   parameter int ERR_CNT_W     = 8,
   parameter int LOCK_THRESH   = 16,
   parameter int UNLOCK_THRESH = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NUM_LANES-1:0]           symbol_valid_i,
   input  logic [NUM_LANES*SYM_W-1:0]     symbols_i,
   input  logic                           clear_cnt_i,
   output logic [NUM_LANES-1:0]           disparity_negative_o,
   output logic [NUM_LANES-1:0]           disp_err_o,
   output logic [NUM_LANES-1:0]           code_err_o,
   output logic [NUM_LANES-1:0]           lane_locked_o,
   output logic [NUM_LANES*ERR_CNT_W-1:0] err_cnt_o
);

   localparam int HALF = SYM_W / 2;
   localparam int CW   = $clog2(SYM_W + 1);
   localparam int GW   = $clog2(LOCK_THRESH + 1);
   localparam int BW   = $clog2(UNLOCK_THRESH + 1);

   typedef enum logic [1:0] {ACQUIRE, CHECK, LOCKED} state_t;

   state_t                state_q [NUM_LANES];
   state_t                state_d [NUM_LANES];
   logic [GW-1:0]         good_q  [NUM_LANES];
   logic [GW-1:0]         good_d  [NUM_LANES];
   logic [BW-1:0]         bad_q   [NUM_LANES];
   logic [BW-1:0]         bad_d   [NUM_LANES];
   logic [ERR_CNT_W-1:0]  cnt_p1  [NUM_LANES];
   logic [ERR_CNT_W-1:0]  cnt_d   [NUM_LANES];
   logic [NUM_LANES-1:0]  rd_neg_p1, rd_neg_d;
   logic [NUM_LANES-1:0]  disp_err_p1, code_err_p1;
   logic [NUM_LANES-1:0]  is_p_p0, is_n_p0, is_z_p0;
   logic [NUM_LANES-1:0]  code_e_p0, disp_e_p0;

   function automatic logic [CW-1:0] count_ones(input logic [SYM_W-1:0] s);
      count_ones = '0;
      for (int i = 0; i < SYM_W; i++) count_ones = count_ones + CW'(s[i]);
   endfunction

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      sat_inc = (&v) ? v : v + ERR_CNT_W'(1);
   endfunction

   // Stage 0: classify each lane's symbol against its current RD and state
   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      logic [CW-1:0] ones_p0;
      assign ones_p0      = count_ones(symbols_i[k*SYM_W +: SYM_W]);
      assign is_p_p0[k]   = (ones_p0 == CW'(HALF + 1));
      assign is_n_p0[k]   = (ones_p0 == CW'(HALF - 1));
      assign is_z_p0[k]   = (ones_p0 == CW'(HALF));
      assign code_e_p0[k] = symbol_valid_i[k] & ~(is_p_p0[k] | is_n_p0[k] | is_z_p0[k]);
      assign disp_e_p0[k] = symbol_valid_i[k] & (state_q[k] != ACQUIRE) &
                            ((is_p_p0[k] & ~rd_neg_p1[k]) | (is_n_p0[k] & rd_neg_p1[k]));
      assign lane_locked_o[k]                       = (state_q[k] == LOCKED);
      assign err_cnt_o[k*ERR_CNT_W +: ERR_CNT_W]    = cnt_p1[k];
   end

   always_comb begin
      for (int k = 0; k < NUM_LANES; k++) begin
         state_d[k] = state_q[k];
         good_d[k]  = good_q[k];
         bad_d[k]   = bad_q[k];
         cnt_d[k]   = cnt_p1[k];
         rd_neg_d[k] = rd_neg_p1[k];
         if (symbol_valid_i[k]) begin
            // RD resyncs to the received symbol even when it was in error
            if (is_p_p0[k]) rd_neg_d[k] = 1'b0;
            if (is_n_p0[k]) rd_neg_d[k] = 1'b1;
            unique case (state_q[k])
               ACQUIRE: begin
                  if (is_p_p0[k] | is_n_p0[k]) begin
                     good_d[k]  = GW'(1);
                     bad_d[k]   = '0;
                     state_d[k] = (LOCK_THRESH == 1) ? LOCKED : CHECK;
                  end
               end
               CHECK: begin
                  if (code_e_p0[k] | disp_e_p0[k]) begin
                     good_d[k] = '0;
                  end else if (good_q[k] == GW'(LOCK_THRESH - 1)) begin
                     good_d[k]  = '0;
                     bad_d[k]   = '0;
                     state_d[k] = LOCKED;
                  end else begin
                     good_d[k] = good_q[k] + GW'(1);
                  end
               end
               LOCKED: begin
                  if (code_e_p0[k] | disp_e_p0[k]) begin
                     if (bad_q[k] == BW'(UNLOCK_THRESH - 1)) begin
                        good_d[k]   = '0;
                        bad_d[k]    = '0;
                        rd_neg_d[k] = 1'b1;
                        state_d[k]  = ACQUIRE;
                     end else begin
                        bad_d[k] = bad_q[k] + BW'(1);
                     end
                  end else begin
                     bad_d[k] = '0;
                  end
               end
               default: state_d[k] = ACQUIRE;
            endcase
            if (code_e_p0[k] | disp_e_p0[k]) cnt_d[k] = sat_inc(cnt_p1[k]);
         end
         if (clear_cnt_i) cnt_d[k] = '0;
      end
   end

   // Stage 1: registered lane state and outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < NUM_LANES; k++) begin
            state_q[k] <= ACQUIRE;
            good_q[k]  <= '0;
            bad_q[k]   <= '0;
            cnt_p1[k]  <= '0;
         end
         rd_neg_p1   <= '1;
         disp_err_p1 <= '0;
         code_err_p1 <= '0;
      end else begin
         for (int k = 0; k < NUM_LANES; k++) begin
            state_q[k] <= state_d[k];
            good_q[k]  <= good_d[k];
            bad_q[k]   <= bad_d[k];
            cnt_p1[k]  <= cnt_d[k];
         end
         rd_neg_p1   <= rd_neg_d;
         disp_err_p1 <= disp_e_p0;
         code_err_p1 <= code_e_p0;
      end
   end

   assign disparity_negative_o = rd_neg_p1;
   assign disp_err_o           = disp_err_p1;
   assign code_err_o           = code_err_p1;

endmodule

// File: tb/tb_rd_lane_monitor.sv
// Scoreboard bench for rd_lane_monitor: directed vectors push hand-computed expected
// outputs into a queue; a monitor pops and compares one entry per clock.
module tb_rd_lane_monitor;
   localparam int NL = 4;
   localparam int SW = 10;
   localparam int EW = 4;

   localparam logic [9:0] P = 10'b0011111010;
   localparam logic [9:0] N = 10'b1100000101;
   localparam logic [9:0] Z = 10'b1010101010;
   localparam logic [9:0] C = 10'b1111111000;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           clr = 1'b0;
   logic [NL-1:0]  vld = '0;
   logic [NL*SW-1:0] syms = '0;
   logic [NL-1:0]  rd_neg, de, ce, lk;
   logic [NL*EW-1:0] cnt;

   typedef struct {
      int          step;
      logic [3:0]  rd, de, ce, lk;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   step_no = 0;

   always #5 clk = ~clk;

   rd_lane_monitor #(
      .NUM_LANES(NL), .SYM_W(SW), .ERR_CNT_W(EW), .LOCK_THRESH(4), .UNLOCK_THRESH(3)
   ) dut (
      .clk_i(clk), .rst_i(rst), .symbol_valid_i(vld), .symbols_i(syms),
      .clear_cnt_i(clr), .disparity_negative_o(rd_neg), .disp_err_o(de),
      .code_err_o(ce), .lane_locked_o(lk), .err_cnt_o(cnt)
   );

   task automatic send(input logic r, input logic c, input logic [3:0] v,
                       input logic [9:0] a0, input logic [9:0] a1,
                       input logic [9:0] a2, input logic [9:0] a3,
                       input logic [3:0] erd, input logic [3:0] ede,
                       input logic [3:0] ece, input logic [3:0] elk,
                       input logic [15:0] ecnt);
      exp_t e;
      @(negedge clk);
      rst  = r;
      clr  = c;
      vld  = v;
      syms = {a3, a2, a1, a0};
      step_no++;
      e.step = step_no;
      e.rd = erd; e.de = ede; e.ce = ece; e.lk = elk; e.cnt = ecnt;
      q.push_back(e);
   endtask

   task automatic chk(input string name, input int step, input logic [15:0] got,
                      input logic [15:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s step=%0d got=%h want=%h", name, step, got, want);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("rd_neg",   e.step, {12'd0, rd_neg}, {12'd0, e.rd});
            chk("disp_err", e.step, {12'd0, de},     {12'd0, e.de});
            chk("code_err", e.step, {12'd0, ce},     {12'd0, e.ce});
            chk("locked",   e.step, {12'd0, lk},     {12'd0, e.lk});
            chk("err_cnt",  e.step, cnt,             e.cnt);
         end
      end
   end

   initial begin : driver
      // reset
      send(1, 0, 4'b0000, Z, Z, Z, Z, 4'b1111, 4'b0, 4'b0, 4'b0, 16'h0000);
      send(1, 0, 4'b0000, Z, Z, Z, Z, 4'b1111, 4'b0, 4'b0, 4'b0, 16'h0000);
      // lock acquisition on lane 0
      send(0, 0, 4'b0001, P, Z, Z, Z, 4'b1110, 4'b0, 4'b0, 4'b0000, 16'h0000);
      send(0, 0, 4'b0001, N, Z, Z, Z, 4'b1111, 4'b0, 4'b0, 4'b0000, 16'h0000);
      send(0, 0, 4'b0001, P, Z, Z, Z, 4'b1110, 4'b0, 4'b0, 4'b0000, 16'h0000);
      send(0, 0, 4'b0001, N, Z, Z, Z, 4'b1111, 4'b0, 4'b0, 4'b0001, 16'h0000);
      // disparity error while locked
      send(0, 0, 4'b0001, P, Z, Z, Z, 4'b1110, 4'b0000, 4'b0, 4'b0001, 16'h0000);
      send(0, 0, 4'b0001, P, Z, Z, Z, 4'b1110, 4'b0001, 4'b0, 4'b0001, 16'h0001);
      send(0, 0, 4'b0001, N, Z, Z, Z, 4'b1111, 4'b0000, 4'b0, 4'b0001, 16'h0001);
      // code error while locked, then recover
      send(0, 0, 4'b0001, C, Z, Z, Z, 4'b1111, 4'b0, 4'b0001, 4'b0001, 16'h0002);
      send(0, 0, 4'b0001, Z, Z, Z, Z, 4'b1111, 4'b0, 4'b0000, 4'b0001, 16'h0002);
      // three consecutive bad symbols drop lock
      send(0, 0, 4'b0001, C, Z, Z, Z, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 16'h0003);
      send(0, 0, 4'b0001, N, Z, Z, Z, 4'b1111, 4'b0001, 4'b0000, 4'b0001, 16'h0004);
      send(0, 0, 4'b0001, C, Z, Z, Z, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 16'h0005);
      send(0, 0, 4'b0001, Z, Z, Z, Z, 4'b1111, 4'b0, 4'b0, 4'b0000, 16'h0005);
      send(0, 0, 4'b0001, Z, Z, Z, Z, 4'b1111, 4'b0, 4'b0, 4'b0000, 16'h0005);
      // ACQUIRE: code errors flagged, disparity never flagged
      send(0, 0, 4'b0001, C, Z, Z, Z, 4'b1111, 4'b0, 4'b0001, 4'b0000, 16'h0006);
      send(0, 0, 4'b0001, N, Z, Z, Z, 4'b1111, 4'b0, 4'b0000, 4'b0000, 16'h0006);
      // saturation of the 4-bit counter
      for (int i = 1; i <= 20; i++)
         send(0, 0, 4'b0001, C, Z, Z, Z, 4'b1111, 4'b0, 4'b0001, 4'b0000,
              16'((6 + i > 15) ? 15 : 6 + i));
      // clear wins over a simultaneous increment
      send(0, 1, 4'b0001, C, Z, Z, Z, 4'b1111, 4'b0, 4'b0001, 4'b0000, 16'h0000);
      send(0, 0, 4'b0001, Z, Z, Z, Z, 4'b1111, 4'b0, 4'b0000, 4'b0000, 16'h0000);
      // lane 2 picks up a count and positive RD before going idle
      send(0, 0, 4'b0100, Z, Z, C, Z, 4'b1111, 4'b0, 4'b0100, 4'b0, 16'h0100);
      send(0, 0, 4'b0100, Z, Z, P, Z, 4'b1011, 4'b0, 4'b0000, 4'b0, 16'h0100);
      // lane independence: lane 2 idle with garbage, lane 1 disparity error
      send(0, 0, 4'b1011, P, P, C, P, 4'b0000, 4'b0000, 4'b0, 4'b0000, 16'h0100);
      send(0, 0, 4'b1011, N, P, C, N, 4'b1001, 4'b0010, 4'b0, 4'b0000, 16'h0110);
      send(0, 0, 4'b1011, P, N, C, P, 4'b0010, 4'b0000, 4'b0, 4'b0001, 16'h0110);
      // mid-stream reset discards the symbol on the reset edge
      send(1, 0, 4'b1111, C, P, C, P, 4'b1111, 4'b0, 4'b0, 4'b0, 16'h0000);
      send(0, 0, 4'b0000, C, P, C, P, 4'b1111, 4'b0, 4'b0, 4'b0, 16'h0000);

      @(negedge clk);
      vld = '0;
      rst = 1'b0;
      clr = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain pending=%0d want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
